// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix scanner: FSM state encoding,
// default geometry and the helpers that derive counter/index widths.
package led_matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    localparam int DEF_ROWS  = 8;
    localparam int DEF_COLS  = 8;
    localparam int DEF_DWELL = 1000;
    localparam int DEF_BLANK = 4;

    function automatic int row_width(input int rows);
        return $clog2(rows);
    endfunction

    function automatic int cnt_width(input int dwell, input int blank);
        int m;
        m = 2;
        if (dwell > m) m = dwell;
        if (blank > m) m = blank;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/led_matrix_fb.sv
// Double frame buffer: writes go to the back buffer, the read port always
// returns the front buffer as it will be after this cycle's swap.
module led_matrix_fb
    import led_matrix_pkg::*;
#(
    parameter  int ROWS  = DEF_ROWS,
    parameter  int COLS  = DEF_COLS,
    localparam int ROW_W = row_width(ROWS)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iWr_en,
    input  logic [ROW_W-1:0] iWr_row,
    input  logic [COLS-1:0]  iWr_data,
    input  logic             iSwap,
    input  logic [ROW_W-1:0] iRd_row,
    output logic [COLS-1:0]  oRd_data
);

    logic [COLS-1:0] buf_q [2][ROWS];
    logic            sel_q;
    logic            sel_d;
    logic            wr_in_range;

    assign sel_d       = sel_q ^ iSwap;
    assign wr_in_range = {1'b0, iWr_row} < (ROW_W + 1)'(ROWS);

    // NOTE: the buffers are small flop arrays, so they clear on the async reset
    // like any other state; <= keeps every flop sampling pre-edge values.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sel_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    buf_q[b][r] <= '0;
                end
            end
        end else begin
            sel_q <= sel_d;
            if (iWr_en && wr_in_range) begin
                buf_q[~sel_q][iWr_row] <= iWr_data;
            end
        end
    end

    // NOTE: assigning a default before any condition keeps always_comb latch-free.
    always_comb begin
        oRd_data = buf_q[sel_d][iRd_row];
        // A write landing in the buffer that turns front at this edge is forwarded.
        if (iWr_en && wr_in_range && iSwap && (iWr_row == iRd_row)) begin
            oRd_data = iWr_data;
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed LED matrix driver: blank/drive row scan over the front
// buffer, with swaps of the double buffer deferred to frame boundaries.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter  int ROWS  = DEF_ROWS,
    parameter  int COLS  = DEF_COLS,
    parameter  int DWELL = DEF_DWELL,
    parameter  int BLANK = DEF_BLANK,
    localparam int ROW_W = row_width(ROWS),
    localparam int CNT_W = cnt_width(DWELL, BLANK)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iEnable,
    input  logic             iWr_valid,
    output logic             oWr_ready,
    input  logic [ROW_W-1:0] iWr_row,
    input  logic [COLS-1:0]  iWr_data,
    input  logic             iSwap,
    output logic             oSwap_done,
    output logic [ROWS-1:0]  oRow,
    output logic [COLS-1:0]  oCol,
    output logic             oFrame_start
);

    // A load value equal to 2**CNT_W truncates to 0 and wraps down through
    // every code to 1, so the period is still exact.
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    scan_state_e      state_q, state_d;
    logic [ROW_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             swap_pending_q, swap_pending_d;
    logic             wr_fire, last_tick, swap_go;
    logic [COLS-1:0]  front_row;
    logic [ROWS-1:0]  row_d;
    logic [COLS-1:0]  col_d;
    logic             frame_start_d;

    assign wr_fire        = iWr_valid && oWr_ready;
    assign last_tick      = (cnt_q == CNT_W'(1));
    assign swap_go        = swap_pending_q &&
                            ((state_q == ST_DRIVE && idx_q == LAST_ROW && last_tick) ||
                             (state_q == ST_IDLE));
    assign swap_pending_d = !swap_go && (swap_pending_q || iSwap);

    led_matrix_fb #(.ROWS(ROWS), .COLS(COLS)) u_fb (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iWr_en   (wr_fire),
        .iWr_row  (iWr_row),
        .iWr_data (iWr_data),
        .iSwap    (swap_go),
        .iRd_row  (idx_d),
        .oRd_data (front_row)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            swap_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!iEnable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    idx_d = '0;
                    if (BLANK > 0) begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LD;
                    end else begin
                        state_d = ST_DRIVE;
                        cnt_d   = DWELL_LD;
                    end
                end
                ST_BLANK: begin
                    if (last_tick) begin
                        state_d = ST_DRIVE;
                        cnt_d   = DWELL_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (last_tick) begin
                        idx_d = (idx_q == LAST_ROW) ? '0 : idx_q + 1'b1;
                        if (BLANK > 0) begin
                            state_d = ST_BLANK;
                            cnt_d   = BLANK_LD;
                        end else begin
                            cnt_d = DWELL_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they describe.
    always_comb begin
        row_d         = '0;
        col_d         = '1;
        frame_start_d = 1'b0;
        if (state_d == ST_DRIVE) begin
            row_d         = ROWS'(1) << idx_d;
            col_d         = ~front_row;
            frame_start_d = (idx_d == '0) && ((state_q != ST_DRIVE) || last_tick);
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oRow         <= '0;
            oCol         <= '1;
            oFrame_start <= 1'b0;
            oSwap_done   <= 1'b0;
            oWr_ready    <= 1'b1;
        end else begin
            oRow         <= row_d;
            oCol         <= col_d;
            oFrame_start <= frame_start_d;
            oSwap_done   <= swap_go;
            oWr_ready    <= !swap_pending_d;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: a 4x5 scanner for the main vectors and
// a 5-row instance so an out-of-range write row can be expressed.
module tb_led_matrix_scan;

    localparam int ROWS  = 4;
    localparam int COLS  = 5;
    localparam int DWELL = 3;
    localparam int BLANK = 1;

    logic iClk = 1'b0;
    logic iRst_n;

    logic       en, wr_valid, swap;
    logic [1:0] wr_row;
    logic [4:0] wr_data;
    logic       wr_ready, swap_done, frame_start;
    logic [3:0] row;
    logic [4:0] col;

    logic       b_en, b_wr_valid, b_swap;
    logic [2:0] b_wr_row;
    logic [4:0] b_wr_data;
    logic       b_wr_ready, b_swap_done, b_frame_start;
    logic [4:0] b_row;
    logic [4:0] b_col;

    always #5 iClk = ~iClk;

    led_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) u_dut (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iEnable      (en),
        .iWr_valid    (wr_valid),
        .oWr_ready    (wr_ready),
        .iWr_row      (wr_row),
        .iWr_data     (wr_data),
        .iSwap        (swap),
        .oSwap_done   (swap_done),
        .oRow         (row),
        .oCol         (col),
        .oFrame_start (frame_start)
    );

    led_matrix_scan #(.ROWS(5), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) u_dut_b (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iEnable      (b_en),
        .iWr_valid    (b_wr_valid),
        .oWr_ready    (b_wr_ready),
        .iWr_row      (b_wr_row),
        .iWr_data     (b_wr_data),
        .iSwap        (b_swap),
        .oSwap_done   (b_swap_done),
        .oRow         (b_row),
        .oCol         (b_col),
        .oFrame_start (b_frame_start)
    );

    typedef struct {
        logic       en;
        logic [3:0] row;
        logic [4:0] col;
        logic       fs;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic add_vec(input logic e, input logic [3:0] r, input logic [4:0] c, input logic f);
        vec_t v;
        v.en  = e;
        v.row = r;
        v.col = c;
        v.fs  = f;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en;
            tick();
            check($sformatf("%s[%0d].row", tag, i), row, vecs[i].row);
            check($sformatf("%s[%0d].col", tag, i), col, vecs[i].col);
            check($sformatf("%s[%0d].fs", tag, i), frame_start, vecs[i].fs);
            check($sformatf("%s[%0d].done", tag, i), swap_done, 1'b0);
        end
        vecs.delete();
    endtask

    task automatic write_row(input logic [1:0] r, input logic [4:0] d, input logic with_swap);
        check("wr_ready_before_write", wr_ready, 1'b1);
        wr_valid = 1'b1;
        wr_row   = r;
        wr_data  = d;
        swap     = with_swap;
        tick();
        wr_valid = 1'b0;
        swap     = 1'b0;
    endtask

    // Called right after the edge that registered iSwap while idle.
    task automatic finish_idle_swap(input string tag);
        check({tag, "_pending_ready"}, wr_ready, 1'b0);
        check({tag, "_pending_done"}, swap_done, 1'b0);
        tick();
        check({tag, "_done_pulse"}, swap_done, 1'b1);
        check({tag, "_ready_back"}, wr_ready, 1'b1);
        tick();
        check({tag, "_done_low"}, swap_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] frame_b [4];
        int         extra_done;

        frame_b[0] = 5'b00001;
        frame_b[1] = 5'b00010;
        frame_b[2] = 5'b00100;
        frame_b[3] = 5'b01000;

        iRst_n = 1'b1;
        en = 0; wr_valid = 0; swap = 0; wr_row = '0; wr_data = '0;
        b_en = 0; b_wr_valid = 0; b_swap = 0; b_wr_row = '0; b_wr_data = '0;

        // Reset values
        #2 iRst_n = 1'b0;
        tick();
        tick();
        check("rst_row", row, 4'b0000);
        check("rst_col", col, 5'b11111);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_done", swap_done, 1'b0);
        check("rst_fs", frame_start, 1'b0);
        iRst_n = 1'b1;
        tick();

        // Single row, swap while idle, then enable
        write_row(2'd0, 5'b10101, 1'b0);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        finish_idle_swap("swapA");
        add_vec(1, 4'b0000, 5'b11111, 0);
        add_vec(1, 4'b0001, 5'b01010, 1);
        add_vec(1, 4'b0001, 5'b01010, 0);
        add_vec(1, 4'b0001, 5'b01010, 0);
        add_vec(1, 4'b0000, 5'b11111, 0);
        add_vec(1, 4'b0010, 5'b11111, 0);
        add_vec(1, 4'b0010, 5'b11111, 0);
        add_vec(0, 4'b0000, 5'b11111, 0);
        run_vecs("single");

        // Four-row frame; last write shares its cycle with the swap request
        write_row(2'd0, frame_b[0], 1'b0);
        write_row(2'd1, frame_b[1], 1'b0);
        write_row(2'd2, frame_b[2], 1'b0);
        write_row(2'd3, frame_b[3], 1'b1);
        finish_idle_swap("swapB");
        for (int k = 1; k <= 34; k++) begin
            int ph, r, p;
            ph = (k - 1) % 16;
            r  = ph / 4;
            p  = ph % 4;
            if (p == 0) add_vec(1, 4'b0000, 5'b11111, 0);
            else        add_vec(1, 4'(1 << r), ~frame_b[r], (r == 0 && p == 1));
        end
        run_vecs("frame");

        // Now at frame slot 1 (first drive cycle of row 0). Swap mid row 1, twice.
        for (int s = 2; s <= 6; s++) tick();
        check("swapC_row1", row, 4'b0010);
        swap = 1'b1;
        for (int s = 7; s <= 15; s++) begin
            tick();
            swap = (s == 8);
            check($sformatf("swapC_ready_s%0d", s), wr_ready, 1'b0);
            check($sformatf("swapC_done_s%0d", s), swap_done, 1'b0);
        end
        tick();
        check("swapC_done_pulse", swap_done, 1'b1);
        check("swapC_ready_back", wr_ready, 1'b1);
        check("swapC_blank_row", row, 4'b0000);
        tick();
        check("swapC_done_low", swap_done, 1'b0);
        check("swapC_new_row", row, 4'b0001);
        check("swapC_new_col", col, 5'b01010);
        check("swapC_fs", frame_start, 1'b1);
        extra_done = 0;
        for (int s = 18; s <= 33; s++) begin
            tick();
            if (swap_done) extra_done++;
        end
        check("swapC_single_done", extra_done, 0);
        check("swapC_next_frame_col", col, 5'b01010);
        check("swapC_next_frame_fs", frame_start, 1'b1);

        // Disable during row 2, re-enable from row 0
        for (int s = 2; s <= 9; s++) tick();
        check("dis_row2", row, 4'b0100);
        en = 1'b0;
        tick();
        check("dis_row_off", row, 4'b0000);
        check("dis_col_off", col, 5'b11111);
        check("dis_fs", frame_start, 1'b0);
        tick();
        check("dis_still_off", row, 4'b0000);
        en = 1'b1;
        tick();
        check("reen_blank", row, 4'b0000);
        tick();
        check("reen_row0", row, 4'b0001);
        check("reen_col0", col, 5'b01010);
        check("reen_fs", frame_start, 1'b1);
        tick();
        check("mid_drive_row", row, 4'b0001);

        // Asynchronous reset mid-DRIVE
        #2 iRst_n = 1'b0;
        #1;
        check("arst_col", col, 5'b11111);
        check("arst_row", row, 4'b0000);
        check("arst_ready", wr_ready, 1'b1);
        check("arst_fs", frame_start, 1'b0);
        en = 1'b0;
        tick();
        iRst_n = 1'b1;
        tick();
        en = 1'b1;
        tick();
        check("post_rst_blank", row, 4'b0000);
        tick();
        check("post_rst_row0", row, 4'b0001);
        check("post_rst_cleared", col, 5'b11111);
        check("post_rst_fs", frame_start, 1'b1);
        en = 1'b0;
        tick();

        // Five-row instance: out-of-range write is accepted and dropped
        check("b_ready_idle", b_wr_ready, 1'b1);
        b_wr_valid = 1'b1;
        b_wr_row   = 3'd5;
        b_wr_data  = 5'b11111;
        tick();
        check("b_ready_after_oor", b_wr_ready, 1'b1);
        b_wr_row  = 3'd4;
        b_wr_data = 5'b00011;
        tick();
        b_wr_valid = 1'b0;
        b_swap     = 1'b1;
        tick();
        b_swap = 1'b0;
        check("b_pending_ready", b_wr_ready, 1'b0);
        tick();
        check("b_done_pulse", b_swap_done, 1'b1);
        b_en = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            int ph, r, p;
            logic [4:0] exp_row, exp_col;
            tick();
            ph = (k - 1) % 20;
            r  = ph / 4;
            p  = ph % 4;
            exp_row = (p == 0) ? 5'b00000 : 5'(1 << r);
            exp_col = (p != 0 && r == 4) ? 5'b11100 : 5'b11111;
            check($sformatf("b_scan[%0d].row", k), b_row, exp_row);
            check($sformatf("b_scan[%0d].col", k), b_col, exp_col);
            check($sformatf("b_scan[%0d].fs", k), b_frame_start, (r == 0 && p == 1));
        end
        b_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
